divider_top_v1: RTL

//  Iterative radix-2 restoring divider for the RV32M accelerator; inverse companion of the multiplier unit.

---
 rtl/divider_top_v1_pkg.sv | 27 ++
 rtl/divider_top_v1_if.sv | 27 ++
 rtl/divider_top_v1_cp.sv | 91 +++++++++
 rtl/divider_top_v1.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/divider_top_v1_pkg.sv
// Shared RV32M definitions for the iterative divider.
//  - div_state_e    : divider control states (3-bit encoding)
//  - rv32m_div_op_e : op-select encoding shared with the multiplier issue logic
//  - DIV_BY_ZERO_Q  : quotient returned for division by zero (all ones)
package divider_top_v1_pkg;

    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } rv32m_div_op_e;

    // Sliced down to XLEN by the user.
    localparam logic [XLEN_MAX-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/divider_top_v1_if.sv
// Issue-side handshake bundle for the divider.
//  master : issue logic (drives request/operands, receives result/status)
//  slave  : divider (receives request/operands, drives result/status)
//  div_en_i start request, op_A_i dividend, op_B_i divisor, signed_i signed op,
//  rem_i select remainder, result_o registered result, busy_o, done_o pulse.
interface divider_top_v1_if #(
    parameter int unsigned XLEN = 32
);
    logic            div_en_i;
    logic [XLEN-1:0] op_A_i;
    logic [XLEN-1:0] op_B_i;
    logic            signed_i;
    logic            rem_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;
    logic            done_o;

    modport master (
        output div_en_i, op_A_i, op_B_i, signed_i, rem_i,
        input  result_o, busy_o, done_o
    );

    modport slave (
        input  div_en_i, op_A_i, op_B_i, signed_i, rem_i,
        output result_o, busy_o, done_o
    );
endinterface

// File: rtl/divider_top_v1_cp.sv
// Divider control path: FSM IDLE -> PREP -> ITER (xXLEN) -> FIX -> DONE -> IDLE
// plus the iteration counter.
//  clk_i, rst_i : clock, synchronous active-high reset
//  start_i      : start request (only honoured in IDLE)
//  special_i    : datapath flags divide-by-zero / overflow during PREP
//  load_o       : capture operands (IDLE and start)
//  prep_o       : PREP cycle strobe
//  shift_o      : one restoring iteration this cycle
//  fix_o        : sign-fix / result load strobe
//  done_o       : one-cycle completion pulse
//  busy_o       : high in PREP/ITER/FIX
module divider_cp_v1
    import divider_top_v1_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic special_i,
    output logic load_o,
    output logic prep_o,
    output logic shift_o,
    output logic fix_o,
    output logic done_o,
    output logic busy_o
);

    localparam int unsigned      CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_o  = 1'b0;
        prep_o  = 1'b0;
        shift_o = 1'b0;
        fix_o   = 1'b0;
        done_o  = 1'b0;
        busy_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                prep_o  = 1'b1;
                busy_o  = 1'b1;
                cnt_d   = '0;
                state_d = special_i ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                shift_o = 1'b1;
                busy_o  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix_o   = 1'b1;
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/divider_top_v1.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit
// per cycle, registered result and single-cycle done pulse.
//  clk_i : clock, rising edge
//  rst_i : synchronous active-high reset; aborts any operation
//  bus   : slave side of divider_top_v1_if (div_en_i, op_A_i, op_B_i,
//          signed_i, rem_i in; result_o, busy_o, done_o out)
// The datapath (operand capture, magnitudes, rem/quo shifter, subtractor,
// sign fix) lives here; sequencing is in divider_cp_v1.
module divider_top_v1
    import divider_top_v1_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    divider_top_v1_if.slave  bus
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO_Q  = DIV_BY_ZERO_Q[XLEN-1:0];

    logic            load, prep, shift, fix, done, busy;

    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic            signed_op_q, signed_op_d;
    logic            rem_op_q, rem_op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] div_mag_q, div_mag_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, overflow, special;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] trial;
    logic            trial_ge;

    divider_cp_v1 #(
        .XLEN (XLEN)
    ) u_cp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (bus.div_en_i),
        .special_i (special),
        .load_o    (load),
        .prep_o    (prep),
        .shift_o   (shift),
        .fix_o     (fix),
        .done_o    (done),
        .busy_o    (busy)
    );

    // PREP-cycle decode, works on the captured operands.
    always_comb begin
        neg_a    = signed_op_q & op_a_q[XLEN-1];
        neg_b    = signed_op_q & op_b_q[XLEN-1];
        abs_a    = neg_a ? ('0 - op_a_q) : op_a_q;
        abs_b    = neg_b ? ('0 - op_b_q) : op_b_q;
        div_zero = (op_b_q == '0);
        overflow = signed_op_q && (op_a_q == MIN_NEG) && (op_b_q == '1);
        special  = div_zero | overflow;
    end

    // One restoring step. rem < |B| always, so the shifted partial remainder
    // needs one extra bit, but the accepted difference fits in XLEN bits.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial_ge = (rem_sh >= {1'b0, div_mag_q});
        trial    = rem_sh[XLEN-1:0] - div_mag_q;
    end

    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        signed_op_d = signed_op_q;
        rem_op_d    = rem_op_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        div_mag_d   = div_mag_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        result_d    = result_q;

        if (load) begin
            op_a_d      = bus.op_A_i;
            op_b_d      = bus.op_B_i;
            signed_op_d = bus.signed_i;
            rem_op_d    = bus.rem_i;
        end

        if (prep) begin
            sign_a_d  = neg_a;
            sign_b_d  = neg_b;
            div_mag_d = abs_b;
            quo_d     = abs_a;
            rem_d     = '0;
            if (div_zero) begin
                result_d = rem_op_q ? op_a_q : ZERO_Q;
            end else if (overflow) begin
                result_d = rem_op_q ? '0 : op_a_q;
            end
        end

        if (shift) begin
            quo_d = {quo_q[XLEN-2:0], trial_ge};
            rem_d = trial_ge ? trial : rem_sh[XLEN-1:0];
        end

        // Remainder sign follows the dividend; quotient sign is the xor.
        if (fix) begin
            if (rem_op_q) begin
                result_d = sign_a_q ? ('0 - rem_q) : rem_q;
            end else begin
                result_d = (sign_a_q ^ sign_b_q) ? ('0 - quo_q) : quo_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            signed_op_q <= 1'b0;
            rem_op_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div_mag_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            result_q    <= '0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            signed_op_q <= signed_op_d;
            rem_op_q    <= rem_op_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            div_mag_q   <= div_mag_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            result_q    <= result_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.busy_o   = busy;
    assign bus.done_o   = done;

endmodule
